// File: rtl/led_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl_pkg
// Shared definitions for the cabin indicator LED sequencer and the display
// logic that decodes its modo output.
//   - state_e     : sequencer states; the encoding is also the modo code
//   - ARR_*_S_DEF : default arrival blink / hold durations in seconds
//   - led_enc()   : {inter, fijo} LED driver pattern for each state
// Configuration macro: LED_LAMP_TEST_EN adds the LAMP_TEST state (modo=6).
// -----------------------------------------------------------------------------
package led_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARR_BLINK = 3'd1,
    ST_ARR_HOLD  = 3'd2,
    ST_DOOR      = 3'd3,
    ST_OVERLOAD  = 3'd4,
`ifdef LED_LAMP_TEST_EN
    ST_FAULT     = 3'd5,
    ST_LAMP_TEST = 3'd6
`else
    ST_FAULT     = 3'd5
`endif
  } state_e;

  localparam int ARR_BLINK_S_DEF = 2;
  localparam int ARR_HOLD_S_DEF  = 3;

  // Returns {inter, fijo}; the two bits are never both set.
  function automatic logic [1:0] led_enc(input state_e s);
    logic [1:0] r;
    r = 2'b00;
    case (s)
      ST_ARR_BLINK, ST_OVERLOAD, ST_FAULT: r = 2'b10;
      ST_ARR_HOLD, ST_DOOR:                r = 2'b01;
`ifdef LED_LAMP_TEST_EN
      ST_LAMP_TEST:                        r = 2'b01;
`endif
      default:                             r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/f_tick_gen.sv
// -----------------------------------------------------------------------------
// f_tick_gen
// Free-running prescaler producing a one-cycle tick every CLK_HZ clocks.
// Counts 0..CLK_HZ-1; tick is high while the count sits at CLK_HZ-1.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (count -> 0)
//   clr  : synchronous restart; the first tick after clr comes CLK_HZ
//          cycles later
//   tick : one-cycle pulse
// -----------------------------------------------------------------------------
module f_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_TOP);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
// Sequencer for the cabin indicator LED driver. Arbitrates fault, overload,
// arrival and door-open requests and times the arrival sequence
// (blink ARR_BLINK_S s, solid ARR_HOLD_S s, then off).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_llegada     : 1-cycle pulse, cabin arrived at a floor
//   req_puerta      : level, door open
//   req_sobrepeso   : level, overload
//   req_falla       : level, fault (latched)
//   clr_falla       : 1-cycle pulse, clears the fault latch if req_falla=0
//   enable_inter    : LED driver blink enable (registered)
//   enable_fijo     : LED driver solid enable (registered)
//   modo            : current state code (registered)
//   falla_act       : latched fault flag
// Configuration macro: LED_LAMP_TEST_EN -- 1 s LAMP_TEST after reset.
// -----------------------------------------------------------------------------
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int ARR_BLINK_S = ARR_BLINK_S_DEF,
  parameter int ARR_HOLD_S  = ARR_HOLD_S_DEF,
  parameter int SEC_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_llegada,
  input  logic       req_puerta,
  input  logic       req_sobrepeso,
  input  logic       req_falla,
  input  logic       clr_falla,
  output logic       enable_inter,
  output logic       enable_fijo,
  output logic [2:0] modo,
  output logic       falla_act
);

`ifdef LED_LAMP_TEST_EN
  localparam state_e RESET_ST = ST_LAMP_TEST;
`else
  localparam state_e RESET_ST = ST_IDLE;
`endif

  state_e           state_q, state_d;
  logic             falla_q, falla_d;
  logic [SEC_W-1:0] sec_q, sec_d, sec_nx;
  logic             tick, restart, entry;
  logic             blink_done, hold_done;
  state_e           hold_exit, hold_entry, arr_entry;
  logic             inter_q, inter_d, fijo_q, fijo_d;
  logic [2:0]       modo_q, modo_d;

  // Set wins over clear. The FSM looks at this next-cycle value so that a
  // fault is acted on (and a clear released) at the same edge the latch moves.
  assign falla_d = req_falla | (falla_q & ~clr_falla);

  assign sec_nx     = tick ? sec_q + SEC_W'(1) : sec_q;
  // Compare the post-tick count so the state changes on the tick that
  // completes the interval, giving exactly N*CLK_HZ cycles in the state.
  assign blink_done = (sec_nx == SEC_W'(ARR_BLINK_S));
  assign hold_done  = (sec_nx == SEC_W'(ARR_HOLD_S));

  // Zero-length phases of the arrival sequence are skipped.
  assign hold_exit  = req_puerta ? ST_DOOR : ST_IDLE;
  assign hold_entry = (ARR_HOLD_S != 0) ? ST_ARR_HOLD : hold_exit;
  assign arr_entry  = (ARR_BLINK_S != 0) ? ST_ARR_BLINK : hold_entry;

  // Next-state logic: fault > overload > arrival sequence > door > idle
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    if (falla_d) begin
      state_d = ST_FAULT;
    end
`ifdef LED_LAMP_TEST_EN
    else if (state_q == ST_LAMP_TEST) begin
      if (tick) state_d = ST_IDLE;
    end
`endif
    else if (req_sobrepeso) begin
      state_d = ST_OVERLOAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_llegada) begin
            state_d = arr_entry;
            restart = 1'b1;
          end else if (req_puerta) begin
            state_d = ST_DOOR;
          end
        end
        ST_DOOR: begin
          if (req_llegada) begin
            state_d = arr_entry;
            restart = 1'b1;
          end else if (!req_puerta) begin
            state_d = ST_IDLE;
          end
        end
        ST_ARR_BLINK: begin
          if (req_llegada) restart = 1'b1;
          else if (blink_done) state_d = hold_entry;
        end
        ST_ARR_HOLD: begin
          if (req_llegada) begin
            state_d = arr_entry;
            restart = 1'b1;
          end else if (hold_done) begin
            state_d = hold_exit;
          end
        end
        ST_OVERLOAD: state_d = hold_exit;
        ST_FAULT:    state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // A restart within the same state must re-arm timing just like an entry.
  assign entry = restart | (state_d != state_q);
  assign sec_d = entry ? '0 : sec_nx;

  f_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (entry),
    .tick(tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RESET_ST;
    else     state_q <= state_d;
  end

  // Fault latch and seconds counter
  always_ff @(posedge clk) begin
    if (rst) begin
      falla_q <= 1'b0;
      sec_q   <= '0;
    end else begin
      falla_q <= falla_d;
      sec_q   <= sec_d;
    end
  end

  // Output decode
  always_comb begin
    modo_d           = 3'(state_q);
    {inter_d, fijo_d} = led_enc(state_q);
  end

  // Output register: outputs trail the state by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      inter_q <= 1'b0;
      fijo_q  <= 1'b0;
      modo_q  <= 3'd0;
    end else begin
      inter_q <= inter_d;
      fijo_q  <= fijo_d;
      modo_q  <= modo_d;
    end
  end

  assign enable_inter = inter_q;
  assign enable_fijo  = fijo_q;
  assign modo         = modo_q;
  assign falla_act    = falla_q;

endmodule
